// File: rtl/fpu_defs_fmac.sv
// Shared FMAC widths, rounding-mode codes and payload types for the normalise/round stage.
package fpu_defs_fmac;

   localparam int unsigned C_MANT  = 23;
   localparam int unsigned C_EXP   = 8;
   localparam int unsigned C_BIAS  = 127;

   localparam int unsigned C_SUM_W = 3*C_MANT + 5;
   localparam int unsigned C_LZC_W = $clog2(C_SUM_W + 1);
   localparam int unsigned C_EIN_W = C_EXP + 2;
   localparam int unsigned C_E_W   = C_EXP + 3;
   localparam int unsigned C_RES_W = C_EXP + C_MANT + 1;

   localparam logic [2:0] C_RM_NEAREST = 3'b000;
   localparam logic [2:0] C_RM_TRUNC   = 3'b001;
   localparam logic [2:0] C_RM_MINUS   = 3'b010;
   localparam logic [2:0] C_RM_PLUS    = 3'b011;

   // Beat held in the first pipeline stage
   typedef struct packed {
      logic [C_SUM_W-1:0] sum;
      logic               sign;
      logic               sticky;
      logic [2:0]         rm;
      logic [C_LZC_W-1:0] lzc;
      logic [C_E_W-1:0]   e;      // two's complement biased exponent after normalisation
      logic               zero;   // sum is all zeros
   } s1_t;

   // Exception flags in port order
   typedef struct packed {
      logic of;
      logic uf;
      logic nx;
   } flags_t;

   // On overflow: 1 -> Inf, 0 -> largest finite of the same sign
   function automatic logic ovf_to_inf(input logic [2:0] rm, input logic sign);
      case (rm)
         C_RM_TRUNC: return 1'b0;
         C_RM_MINUS: return sign;
         C_RM_PLUS:  return ~sign;
         default:    return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/fmac_lzc.sv
// Combinational leading-zero counter over the adder sum width.
module fmac_lzc
   import fpu_defs_fmac::*;
(
   input  logic [C_SUM_W-1:0] i_data,
   output logic [C_LZC_W-1:0] o_cnt,
   output logic               o_zero
);

   // Ascending scan: the highest set bit wins, giving the leading-zero count
   always_comb begin
      o_cnt  = C_LZC_W'(C_SUM_W);
      o_zero = ~|i_data;
      for (int i = 0; i < int'(C_SUM_W); i++) begin
         if (i_data[i]) begin
            o_cnt = C_LZC_W'(int'(C_SUM_W) - 1 - i);
         end
      end
   end

endmodule

// File: rtl/fmac_norm_round.sv
// FMAC result stage: normalise the adder sum, round to binary32, pack result and flags.
// Two registered stages with valid/ready handshake on both sides.
module fmac_norm_round
   import fpu_defs_fmac::*;
(
   input  logic                Clk_CI,
   input  logic                Rst_RI,
   input  logic                Valid_SI,
   output logic                Ready_SO,
   input  logic [C_SUM_W-1:0]  Sum_pos_DI,
   input  logic                Sign_DI,
   input  logic [C_EIN_W-1:0]  Exp_DI,
   input  logic                Sticky_DI,
   input  logic [2:0]          Rnd_mode_SI,
   output logic                Valid_SO,
   input  logic                Ready_SI,
   output logic [C_RES_W-1:0]  Result_DO,
   output logic [2:0]          Flags_DO
);

   localparam int unsigned C_MNT_W = C_MANT + 1;           // kept mantissa incl. hidden bit
   localparam int unsigned C_G_POS = C_SUM_W - C_MNT_W - 1; // guard bit position after shift

   // ---------------- stage 1: leading-zero count and exponent ----------------
   logic [C_LZC_W-1:0] w_lzc;
   logic               w_zero;
   logic [C_E_W-1:0]   w_e_in;
   s1_t                w_s1_d;

   logic               r_v1;
   s1_t                r_s1;

   logic               r_v2;
   logic [C_RES_W-1:0] r_res;
   flags_t             r_flags;

   logic               w_en1;
   logic               w_en2;

   fmac_lzc u_lzc (
      .i_data (Sum_pos_DI),
      .o_cnt  (w_lzc),
      .o_zero (w_zero)
   );

   // Biased exponent of the value once its leading one sits at the top of the sum
   assign w_e_in = C_E_W'(signed'(Exp_DI)) + C_E_W'(C_MANT + 4) - C_E_W'(w_lzc);

   assign w_s1_d = '{sum:    Sum_pos_DI,
                     sign:   Sign_DI,
                     sticky: Sticky_DI,
                     rm:     Rnd_mode_SI,
                     lzc:    w_lzc,
                     e:      w_e_in,
                     zero:   w_zero};

   // ---------------- handshake ----------------
   assign w_en2    = ~r_v2 | Ready_SI;
   assign w_en1    = ~r_v1 | w_en2;
   assign Ready_SO = w_en1;

   // ---------------- stage 2: normalise ----------------
   logic               w_tiny;
   logic [C_E_W-1:0]   w_lsh_s;   // signed: lzc + E - 1, the subnormal left-shift limit
   logic [C_E_W-1:0]   w_rsh;
   logic [C_SUM_W-1:0] w_norm;
   logic               w_shst;

   assign w_tiny  = r_s1.zero | r_s1.e[C_E_W-1] | (r_s1.e == '0);
   assign w_lsh_s = C_E_W'(r_s1.lzc) + r_s1.e - C_E_W'(1);
   assign w_rsh   = C_E_W'(0) - w_lsh_s;

   // Shift the sum so the kept mantissa occupies the top bits; right shifts feed sticky
   always_comb begin
      w_norm = '0;
      w_shst = 1'b0;
      if (w_tiny && w_lsh_s[C_E_W-1]) begin
         if (w_rsh >= C_E_W'(C_SUM_W)) begin
            w_shst = |r_s1.sum;
         end else begin
            w_norm = r_s1.sum >> w_rsh;
            w_shst = |(r_s1.sum & ~({C_SUM_W{1'b1}} << w_rsh));
         end
      end else if (w_tiny) begin
         w_norm = r_s1.sum << w_lsh_s[C_LZC_W-1:0];
      end else begin
         w_norm = r_s1.sum << r_s1.lzc;
      end
   end

   // ---------------- stage 2: round and pack ----------------
   logic [C_MNT_W-1:0] w_mant;
   logic               w_g;
   logic               w_s;
   logic               w_inc;
   logic [C_MNT_W:0]   w_mant_rnd;
   logic               w_carry;
   logic [C_E_W-1:0]   w_e_rnd;
   logic               w_of;
   logic [C_RES_W-1:0] w_res;
   flags_t             w_flags;

   // Apply the rounding increment, handle mantissa carry, overflow and exact zero
   always_comb begin
      w_mant     = w_norm[C_SUM_W-1 -: C_MNT_W];
      w_g        = w_norm[C_G_POS];
      w_s        = (|w_norm[C_G_POS-1:0]) | r_s1.sticky | w_shst;
      w_inc      = 1'b0;
      w_mant_rnd = '0;
      w_carry    = 1'b0;
      w_e_rnd    = '0;
      w_of       = 1'b0;
      w_res      = '0;
      w_flags    = '0;

      case (r_s1.rm)
         C_RM_TRUNC: w_inc = 1'b0;
         C_RM_MINUS: w_inc = r_s1.sign & (w_g | w_s);
         C_RM_PLUS:  w_inc = ~r_s1.sign & (w_g | w_s);
         default:    w_inc = w_g & (w_s | w_mant[0]);
      endcase

      w_mant_rnd = {1'b0, w_mant} + (C_MNT_W + 1)'(w_inc);

      // Normal carry bumps the exponent; a subnormal reaching the hidden bit becomes exp 1
      if (w_tiny) begin
         w_e_rnd = C_E_W'(w_mant_rnd[C_MANT]);
      end else begin
         w_carry = w_mant_rnd[C_MNT_W];
         w_e_rnd = r_s1.e + C_E_W'(w_carry);
      end

      w_of       = ~w_tiny & (w_e_rnd >= C_E_W'((1 << C_EXP) - 1));
      w_flags.of = w_of;
      w_flags.nx = w_g | w_s | w_of;
      w_flags.uf = w_tiny & w_flags.nx;

      if (w_of) begin
         if (ovf_to_inf(r_s1.rm, r_s1.sign)) begin
            w_res = {r_s1.sign, {C_EXP{1'b1}}, {C_MANT{1'b0}}};
         end else begin
            w_res = {r_s1.sign, {(C_EXP-1){1'b1}}, 1'b0, {C_MANT{1'b1}}};
         end
      end else begin
         w_res = {r_s1.sign, w_e_rnd[C_EXP-1:0], w_mant_rnd[C_MANT-1:0]};
      end

      if (r_s1.zero && !r_s1.sticky) begin
         w_res   = {(r_s1.rm == C_RM_MINUS), (C_RES_W-1)'(0)};
         w_flags = '0;
      end
   end

   // ---------------- registers ----------------
   // Stage 1 capture when empty or advancing
   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         r_v1 <= 1'b0;
         r_s1 <= '0;
      end else if (w_en1) begin
         r_v1 <= Valid_SI;
         if (Valid_SI) begin
            r_s1 <= w_s1_d;
         end
      end
   end

   // Stage 2 capture when empty or transferring; holds result under backpressure
   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         r_v2    <= 1'b0;
         r_res   <= '0;
         r_flags <= '0;
      end else if (w_en2) begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_res   <= w_res;
            r_flags <= w_flags;
         end
      end
   end

   assign Valid_SO  = r_v2;
   assign Result_DO = r_res;
   assign Flags_DO  = r_flags;

endmodule

// File: tb/tb_fmac_norm_round.sv
// Bench for fmac_norm_round: directed vectors, handshake corner cases and random traffic
// checked against an exact-arithmetic rounding model.
module tb_fmac_norm_round;
   import fpu_defs_fmac::*;

   logic        Clk_CI = 1'b0;
   logic        Rst_RI;
   logic        Valid_SI;
   logic        Ready_SO;
   logic [73:0] Sum_pos_DI;
   logic        Sign_DI;
   logic [9:0]  Exp_DI;
   logic        Sticky_DI;
   logic [2:0]  Rnd_mode_SI;
   logic        Valid_SO;
   logic        Ready_SI;
   logic [31:0] Result_DO;
   logic [2:0]  Flags_DO;

   int n_total = 0;
   int n_bad   = 0;
   int n_acc   = 0;
   int n_xfer  = 0;
   logic [34:0] exp_q[$];

   fmac_norm_round dut (
      .Clk_CI      (Clk_CI),
      .Rst_RI      (Rst_RI),
      .Valid_SI    (Valid_SI),
      .Ready_SO    (Ready_SO),
      .Sum_pos_DI  (Sum_pos_DI),
      .Sign_DI     (Sign_DI),
      .Exp_DI      (Exp_DI),
      .Sticky_DI   (Sticky_DI),
      .Rnd_mode_SI (Rnd_mode_SI),
      .Valid_SO    (Valid_SO),
      .Ready_SI    (Ready_SI),
      .Result_DO   (Result_DO),
      .Flags_DO    (Flags_DO)
   );

   always #5 Clk_CI = ~Clk_CI;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // value = sum * 2^(exp-173); quantise to the binary32 grid then round by mode
   function automatic logic [34:0] ref_model(input logic [73:0] sum, input logic sign,
                                             input logic signed [9:0] exp, input logic sticky,
                                             input logic [2:0] rm);
      int p, biased, sh, r, e;
      logic [25:0] q;
      logic g, s, inc, tiny, of, nx, inf;
      logic [2:0] rn;
      logic [31:0] res;
      rn = (rm > 3'd3) ? 3'd0 : rm;
      if (sum == 0 && !sticky) return {(rm == 3'd2), 31'd0, 3'b000};
      g = 1'b0; s = sticky; q = '0; e = 0;
      if (sum == 0) begin
         tiny = 1'b1;
      end else begin
         p = 0;
         for (int i = 0; i < 74; i++) if (sum[i]) p = i;
         biased = p + int'(exp) - 46;
         tiny = (biased < 1);
         sh = tiny ? int'(exp) - 24 : 23 - p;
         e  = tiny ? 0 : biased;
         if (sh >= 0) begin
            q = 26'(sum << sh);
         end else begin
            r = -sh;
            q = (r >= 74) ? 26'd0 : 26'(sum >> r);
            for (int i = 0; i < 74; i++) begin
               if (i == r - 1) g = sum[i];
               else if (i < r - 1) s = s | sum[i];
            end
         end
      end
      case (rn)
         3'd1:    inc = 1'b0;
         3'd2:    inc = sign & (g | s);
         3'd3:    inc = ~sign & (g | s);
         default: inc = g & (s | q[0]);
      endcase
      q = q + 26'(inc);
      if (!tiny && q[24]) begin q = q >> 1; e = e + 1; end
      if (tiny && q[23]) e = 1;
      of = !tiny && (e >= 255);
      nx = g | s | of;
      if (of) begin
         inf = (rn == 3'd0) || (rn == 3'd3 && !sign) || (rn == 3'd2 && sign);
         res = inf ? {sign, 8'hFF, 23'd0} : {sign, 8'hFE, 23'h7FFFFF};
      end else begin
         res = {sign, 8'(e), q[22:0]};
      end
      return {res, of, tiny & nx, nx};
   endfunction

   task automatic drive_rand();
      logic [95:0] raw;
      int t;
      raw = {$urandom, $urandom, $urandom};
      Sum_pos_DI = 74'(raw) >> $urandom_range(0, 74);
      if ($urandom_range(0, 19) == 0) Sum_pos_DI = '0;
      case ($urandom_range(0, 3))
         0:       t = int'($urandom_range(0, 90)) - 60;
         1:       t = int'($urandom_range(0, 120)) + 70;
         2:       t = int'($urandom_range(0, 90)) + 190;
         default: t = int'($urandom_range(0, 1023)) - 512;
      endcase
      Exp_DI      = 10'(t);
      Sign_DI     = 1'($urandom);
      Sticky_DI   = ($urandom_range(0, 3) == 0);
      Rnd_mode_SI = 3'($urandom);
   endtask

   // One clock with scoreboard bookkeeping; outputs sampled mid-cycle
   task automatic tick();
      logic acc, xfer, hold;
      logic [34:0] held, want;
      #1;
      acc  = Valid_SI & Ready_SO;
      xfer = Valid_SO & Ready_SI;
      hold = Valid_SO & ~Ready_SI;
      held = {Result_DO, Flags_DO};
      if (xfer) begin
         n_xfer++;
         chk("out_expected", 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            chk("result", 64'(Result_DO), 64'(want[34:3]));
            chk("flags", 64'(Flags_DO), 64'(want[2:0]));
         end
      end
      if (acc) begin
         n_acc++;
         exp_q.push_back(ref_model(Sum_pos_DI, Sign_DI, Exp_DI, Sticky_DI, Rnd_mode_SI));
      end
      @(posedge Clk_CI);
      #1;
      if (hold) chk("hold_stable", 64'({Valid_SO, Result_DO, Flags_DO}), 64'({1'b1, held}));
   endtask

   typedef struct {
      logic [73:0]       sum;
      logic              sign;
      logic signed [9:0] exp;
      logic              sticky;
      logic [2:0]        rm;
      logic [31:0]       res;
      logic [2:0]        flg;
   } vec_t;

   localparam logic [73:0] S1   = 74'(1) << 46;
   localparam logic [73:0] S1G  = (74'(1) << 46) | (74'(1) << 22);
   localparam logic [73:0] S3   = 74'(3) << 46;
   localparam logic [73:0] SCY  = ((74'(1) << 25) - 74'(1)) << 22;
   localparam logic [73:0] SSUB = ((74'(1) << 24) - 74'(1)) << 22;

   vec_t vecs[15];

   initial begin
      int base_acc, base_xfer, guard;

      vecs[0]  = '{S1,   1'b0,  10'sd127, 1'b0, C_RM_NEAREST, 32'h3F800000, 3'b000};
      vecs[1]  = '{S1G,  1'b0,  10'sd127, 1'b0, C_RM_NEAREST, 32'h3F800000, 3'b001};
      vecs[2]  = '{S1G,  1'b0,  10'sd127, 1'b1, C_RM_NEAREST, 32'h3F800001, 3'b001};
      vecs[3]  = '{S3,   1'b0,  10'sd254, 1'b0, C_RM_NEAREST, 32'h7F800000, 3'b101};
      vecs[4]  = '{S3,   1'b0,  10'sd254, 1'b0, C_RM_TRUNC,   32'h7F7FFFFF, 3'b101};
      vecs[5]  = '{S1,   1'b0,  -10'sd3,  1'b0, C_RM_NEAREST, 32'h00080000, 3'b000};
      vecs[6]  = '{S1,   1'b0,  -10'sd25, 1'b0, C_RM_NEAREST, 32'h00000000, 3'b011};
      vecs[7]  = '{74'd0, 1'b0, 10'sd100, 1'b0, C_RM_MINUS,   32'h80000000, 3'b000};
      vecs[8]  = '{74'd0, 1'b1, 10'sd100, 1'b0, C_RM_NEAREST, 32'h00000000, 3'b000};
      vecs[9]  = '{74'd0, 1'b0, 10'sd0,   1'b1, C_RM_PLUS,    32'h00000001, 3'b011};
      vecs[10] = '{74'd0, 1'b1, 10'sd0,   1'b1, C_RM_MINUS,   32'h80000001, 3'b011};
      vecs[11] = '{SCY,  1'b0,  10'sd127, 1'b0, C_RM_NEAREST, 32'h40000000, 3'b001};
      vecs[12] = '{SSUB, 1'b0,  10'sd1,   1'b0, C_RM_NEAREST, 32'h00800000, 3'b011};
      vecs[13] = '{S3,   1'b1,  10'sd254, 1'b0, C_RM_PLUS,    32'hFF7FFFFF, 3'b101};
      vecs[14] = '{S1G,  1'b0,  10'sd127, 1'b1, 3'b101,       32'h3F800001, 3'b001};

      Rst_RI = 1'b1; Valid_SI = 1'b0; Ready_SI = 1'b0;
      Sum_pos_DI = '0; Sign_DI = 1'b0; Exp_DI = '0; Sticky_DI = 1'b0; Rnd_mode_SI = '0;
      repeat (3) @(posedge Clk_CI);
      #1;
      Rst_RI = 1'b0;
      #1;
      chk("rst_valid", 64'(Valid_SO), 64'd0);
      chk("rst_result", 64'(Result_DO), 64'd0);
      chk("rst_flags", 64'(Flags_DO), 64'd0);
      chk("rst_ready", 64'(Ready_SO), 64'd1);

      // Directed vectors, one beat at a time, with latency check
      for (int i = 0; i < 15; i++) begin
         Sum_pos_DI = vecs[i].sum; Sign_DI = vecs[i].sign; Exp_DI = vecs[i].exp;
         Sticky_DI = vecs[i].sticky; Rnd_mode_SI = vecs[i].rm;
         Valid_SI = 1'b1; Ready_SI = 1'b1;
         #1;
         chk($sformatf("v%0d_ready", i), 64'(Ready_SO), 64'd1);
         @(posedge Clk_CI); #1;
         Valid_SI = 1'b0;
         chk($sformatf("v%0d_lat1", i), 64'(Valid_SO), 64'd0);
         @(posedge Clk_CI); #1;
         chk($sformatf("v%0d_valid", i), 64'(Valid_SO), 64'd1);
         chk($sformatf("v%0d_result", i), 64'(Result_DO), 64'(vecs[i].res));
         chk($sformatf("v%0d_flags", i), 64'(Flags_DO), 64'(vecs[i].flg));
         @(posedge Clk_CI); #1;
      end

      // Backpressure: three beats offered, only two fit
      Ready_SI = 1'b0;
      base_acc = n_acc; base_xfer = n_xfer;
      drive_rand(); Valid_SI = 1'b1; tick();
      drive_rand(); tick();
      drive_rand();
      #1;
      chk("bp_ready_drop", 64'(Ready_SO), 64'd0);
      repeat (3) tick();
      chk("bp_accepts", 64'(n_acc - base_acc), 64'd2);
      Ready_SI = 1'b1;
      tick();
      Valid_SI = 1'b0;
      guard = 0;
      while ((exp_q.size() > 0 || Valid_SO) && guard < 20) begin tick(); guard++; end
      chk("bp_drain_bound", 64'(guard < 20), 64'd1);
      chk("bp_accepts_total", 64'(n_acc - base_acc), 64'd3);
      chk("bp_xfers", 64'(n_xfer - base_xfer), 64'd3);

      // Reset with two beats in flight
      Ready_SI = 1'b0;
      drive_rand(); Valid_SI = 1'b1; tick();
      drive_rand(); tick();
      Valid_SI = 1'b0;
      Rst_RI = 1'b1;
      @(posedge Clk_CI); #1;
      Rst_RI = 1'b0;
      exp_q.delete();
      chk("rst_mid_valid", 64'(Valid_SO), 64'd0);
      chk("rst_mid_result", 64'(Result_DO), 64'd0);
      Ready_SI = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("rst_no_stale", 64'(Valid_SO), 64'd0);
      end

      // Random traffic against the model
      for (int c = 0; c < 1500; c++) begin
         drive_rand();
         Valid_SI = ($urandom_range(0, 9) < 7);
         Ready_SI = ($urandom_range(0, 9) < 7);
         tick();
      end
      Valid_SI = 1'b0; Ready_SI = 1'b1;
      guard = 0;
      while ((exp_q.size() > 0 || Valid_SO) && guard < 20) begin tick(); guard++; end
      chk("rand_drained", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
